// File: rtl/rv32i_ctrl_pkg.sv
// Shared opcode constants, control encodings and the control bundle carried
// down the pipeline by pipe_ctrl_unit.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_R       = 7'b0110011;
    localparam logic [6:0] OP_I       = 7'b0010011;
    localparam logic [6:0] OP_I_LD    = 7'b0000011;
    localparam logic [6:0] OP_I_FENCE = 7'b0001111;
    localparam logic [6:0] OP_I_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S       = 7'b0100011;
    localparam logic [6:0] OP_B       = 7'b1100011;
    localparam logic [6:0] OP_U_LUI   = 7'b0110111;
    localparam logic [6:0] OP_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J       = 7'b1101111;

    localparam int ALU_OP_W  = 2;
    localparam int REG_SRC_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_FUNCT = 2'd0,
        ALU_ADD   = 2'd1,
        ALU_SUB   = 2'd2
    } alu_op_e;

    typedef enum logic [REG_SRC_W-1:0] {
        SRC_ALU    = 2'd0,
        SRC_MEM    = 2'd1,
        SRC_PC_IMM = 2'd2,
        SRC_PC4    = 2'd3
    } reg_src_e;

    typedef struct packed {
        alu_op_e  alu_op;
        logic     alu_src;
        logic     branch;
        logic     mem_read;
        logic     mem_write;
        logic     reg_write;
        reg_src_e reg_src;
    } ctrl_t;

    // Register-type defaults; every other opcode is a delta from this.
    localparam ctrl_t CTRL_R = '{alu_op: ALU_FUNCT, alu_src: 1'b0, branch: 1'b0,
                                 mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b1,
                                 reg_src: SRC_ALU};

    localparam ctrl_t CTRL_NOP = '{alu_op: ALU_FUNCT, alu_src: 1'b0, branch: 1'b0,
                                   mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
                                   reg_src: SRC_ALU};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I opcode decoder: control bundle, legality and which
// source registers the instruction actually reads.
module ctrl_decode
    import rv32i_ctrl_pkg::*;
#(
    parameter bit FENCE_NOP = 1'b1
) (
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       legal_o,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        ctrl_o     = CTRL_R;
        legal_o    = 1'b1;
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b0;
        case (opcode_i)
            OP_R: begin
                uses_rs2_o = 1'b1;
            end
            OP_I: begin
                ctrl_o.alu_src = 1'b1;
            end
            OP_I_LD: begin
                ctrl_o.alu_op   = ALU_ADD;
                ctrl_o.alu_src  = 1'b1;
                ctrl_o.mem_read = 1'b1;
                ctrl_o.reg_src  = SRC_MEM;
            end
            OP_I_JALR: begin
                ctrl_o.alu_src = 1'b1;
                ctrl_o.reg_src = SRC_PC4;
            end
            OP_S: begin
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.reg_write = 1'b0;
                uses_rs2_o       = 1'b1;
            end
            OP_U_LUI: begin
                ctrl_o.alu_op  = ALU_ADD;
                ctrl_o.alu_src = 1'b1;
                uses_rs1_o     = 1'b0;
            end
            OP_U_AUIPC: begin
                ctrl_o.reg_src = SRC_PC_IMM;
                uses_rs1_o     = 1'b0;
            end
            OP_J: begin
                ctrl_o.reg_src = SRC_PC4;
                uses_rs1_o     = 1'b0;
            end
            OP_B: begin
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.branch    = 1'b1;
                ctrl_o.reg_write = 1'b0;
                uses_rs2_o       = 1'b1;
            end
            OP_I_FENCE: begin
                ctrl_o     = CTRL_NOP;
                legal_o    = FENCE_NOP;
                uses_rs1_o = 1'b0;
            end
            default: begin
                ctrl_o     = CTRL_NOP;
                legal_o    = 1'b0;
                uses_rs1_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in ID, carries control through EX/MEM/WB,
// interlocks load-use hazards, squashes on redirects and flags illegal opcodes.
module pipe_ctrl_unit
    import rv32i_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit HAZ_DETECT = 1'b1,
    parameter bit FENCE_NOP  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_redirect,
    input  logic                  ext_stall,
    input  logic                  illegal_clr,
    output logic                  id_stall,
    output logic                  if_flush,
    output logic                  ex_valid,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_mem_read,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_valid,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_valid,
    output logic                  wb_reg_write,
    output logic [1:0]            wb_reg_src,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  illegal_op
);

    typedef struct packed {
        logic                  valid;
        ctrl_t                 ctrl;
        logic [REG_ADDR_W-1:0] rd;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        reg_src_e              reg_src;
        logic [REG_ADDR_W-1:0] rd;
    } mem_stage_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        reg_src_e              reg_src;
        logic [REG_ADDR_W-1:0] rd;
    } wb_stage_t;

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q,  wb_d;
    logic       illegal_q, illegal_d;

    ctrl_t dec_ctrl;
    logic  dec_legal, dec_uses_rs1, dec_uses_rs2;

    ctrl_decode #(.FENCE_NOP(FENCE_NOP)) u_decode (
        .opcode_i   (id_opcode),
        .ctrl_o     (dec_ctrl),
        .legal_o    (dec_legal),
        .uses_rs1_o (dec_uses_rs1),
        .uses_rs2_o (dec_uses_rs2)
    );

    logic rs_hit, load_use, id_issue, illegal_set;

    always_comb begin
        rs_hit = (dec_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                 (dec_uses_rs2 && (id_rs2 == ex_q.rd));
        load_use = HAZ_DETECT && id_valid && ex_q.valid && ex_q.ctrl.mem_read &&
                   (ex_q.rd != '0) && rs_hit;
        // A redirect squashes the ID instruction, so it neither stalls nor flags.
        id_issue    = id_valid && dec_legal && !ex_redirect && !load_use;
        illegal_set = id_valid && !dec_legal && !ex_redirect && !load_use;
        id_stall    = ext_stall || (load_use && !ex_redirect);
        if_flush    = ex_redirect && !ext_stall;
    end

    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        illegal_d = illegal_q;
        if (!ext_stall) begin
            wb_d.valid     = mem_q.valid;
            wb_d.reg_write = mem_q.reg_write;
            wb_d.reg_src   = mem_q.reg_src;
            wb_d.rd        = mem_q.rd;

            mem_d.valid     = ex_q.valid;
            mem_d.mem_read  = ex_q.ctrl.mem_read;
            mem_d.mem_write = ex_q.ctrl.mem_write;
            mem_d.reg_write = ex_q.ctrl.reg_write;
            mem_d.reg_src   = ex_q.ctrl.reg_src;
            mem_d.rd        = ex_q.rd;

            ex_d = '0;
            if (id_issue) begin
                ex_d.valid          = 1'b1;
                ex_d.ctrl           = dec_ctrl;
                ex_d.ctrl.reg_write = dec_ctrl.reg_write && (id_rd != '0);
                ex_d.rd             = id_rd;
            end

            if (illegal_set) begin
                illegal_d = 1'b1;
            end else if (illegal_clr) begin
                illegal_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every stage samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_alu_op    = ex_q.ctrl.alu_op;
    assign ex_alu_src   = ex_q.ctrl.alu_src;
    assign ex_branch    = ex_q.ctrl.branch;
    assign ex_mem_read  = ex_q.ctrl.mem_read;
    assign ex_rd        = ex_q.rd;
    assign mem_valid    = mem_q.valid;
    assign mem_read     = mem_q.mem_read;
    assign mem_write    = mem_q.mem_write;
    assign mem_rd       = mem_q.rd;
    assign wb_valid     = wb_q.valid;
    assign wb_reg_write = wb_q.reg_write;
    assign wb_reg_src   = wb_q.reg_src;
    assign wb_rd        = wb_q.rd;
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: expected stage contents are queued as
// instructions are driven and compared as they move through EX/MEM/WB.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, ext_stall, illegal_clr;

    logic       id_stall, if_flush, ex_valid, ex_alu_src, ex_branch, ex_mem_read;
    logic [1:0] ex_alu_op, wb_reg_src;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       mem_valid, mem_read, mem_write, wb_valid, wb_reg_write, illegal_op;

    logic       d2_id_stall, d2_if_flush, d2_ex_valid, d2_ex_alu_src, d2_ex_branch, d2_ex_mem_read;
    logic [1:0] d2_ex_alu_op, d2_wb_reg_src;
    logic [4:0] d2_ex_rd, d2_mem_rd, d2_wb_rd;
    logic       d2_mem_valid, d2_mem_read, d2_mem_write, d2_wb_valid, d2_wb_reg_write, d2_illegal_op;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .HAZ_DETECT(1'b1), .FENCE_NOP(1'b1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .ext_stall(ext_stall), .illegal_clr(illegal_clr), .id_stall(id_stall),
        .if_flush(if_flush), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rd(mem_rd), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_reg_src(wb_reg_src), .wb_rd(wb_rd), .illegal_op(illegal_op)
    );

    pipe_ctrl_unit #(.REG_ADDR_W(5), .HAZ_DETECT(1'b0), .FENCE_NOP(1'b0)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .ext_stall(ext_stall), .illegal_clr(illegal_clr), .id_stall(d2_id_stall),
        .if_flush(d2_if_flush), .ex_valid(d2_ex_valid), .ex_alu_op(d2_ex_alu_op),
        .ex_alu_src(d2_ex_alu_src), .ex_branch(d2_ex_branch), .ex_mem_read(d2_ex_mem_read),
        .ex_rd(d2_ex_rd), .mem_valid(d2_mem_valid), .mem_read(d2_mem_read),
        .mem_write(d2_mem_write), .mem_rd(d2_mem_rd), .wb_valid(d2_wb_valid),
        .wb_reg_write(d2_wb_reg_write), .wb_reg_src(d2_wb_reg_src), .wb_rd(d2_wb_rd),
        .illegal_op(d2_illegal_op)
    );

    logic [30:0] d1_all, d2_all;
    assign d1_all = {id_stall, if_flush, ex_valid, ex_alu_op, ex_alu_src, ex_branch,
                     ex_mem_read, ex_rd, mem_valid, mem_read, mem_write, mem_rd,
                     wb_valid, wb_reg_write, wb_reg_src, wb_rd, illegal_op};
    assign d2_all = {d2_id_stall, d2_if_flush, d2_ex_valid, d2_ex_alu_op, d2_ex_alu_src,
                     d2_ex_branch, d2_ex_mem_read, d2_ex_rd, d2_mem_valid, d2_mem_read,
                     d2_mem_write, d2_mem_rd, d2_wb_valid, d2_wb_reg_write, d2_wb_reg_src,
                     d2_wb_rd, d2_illegal_op};

    typedef struct packed {
        logic       v;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_src;
        logic [4:0] rd;
    } exp_t;

    localparam exp_t BUB = '0;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Expected control bundle straight from the opcode table.
    function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd);
        exp_t e;
        e           = '0;
        e.v         = 1'b1;
        e.rd        = rd;
        e.reg_write = 1'b1;
        case (op)
            7'h33: ;
            7'h13: e.alu_src = 1'b1;
            7'h03: begin e.alu_op = 2'd1; e.alu_src = 1'b1; e.mem_read = 1'b1; e.reg_src = 2'd1; end
            7'h67: begin e.alu_src = 1'b1; e.reg_src = 2'd3; end
            7'h23: begin e.alu_op = 2'd1; e.alu_src = 1'b1; e.mem_write = 1'b1; e.reg_write = 1'b0; end
            7'h37: begin e.alu_op = 2'd1; e.alu_src = 1'b1; end
            7'h17: e.reg_src = 2'd2;
            7'h6F: e.reg_src = 2'd3;
            7'h63: begin e.alu_op = 2'd2; e.branch = 1'b1; e.reg_write = 1'b0; end
            7'h0F: e.reg_write = 1'b0;
            default: e = '0;
        endcase
        if (rd == 5'd0) e.reg_write = 1'b0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs1    = rs1;
        id_rs2    = rs2;
        id_rd     = rd;
    endtask

    task automatic idle();
        drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0);
    endtask

    // One clock edge; the queue holds expected {WB, MEM, EX} contents.
    task automatic sb_step(input exp_t enter, input bit hold);
        exp_t gone;
        @(posedge clk);
        @(negedge clk);
        if (!hold) begin
            gone = q.pop_front();
            q.push_back(enter);
        end
        checks++;
        if ({ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_mem_read, ex_rd} !==
            {q[2].v, q[2].alu_op, q[2].alu_src, q[2].branch, q[2].mem_read, q[2].rd}) begin
            failures++;
            $display("FAIL ex_stage t=%0t got=%b exp=%b", $time,
                     {ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_mem_read, ex_rd},
                     {q[2].v, q[2].alu_op, q[2].alu_src, q[2].branch, q[2].mem_read, q[2].rd});
        end
        checks++;
        if ({mem_valid, mem_read, mem_write, mem_rd} !==
            {q[1].v, q[1].mem_read, q[1].mem_write, q[1].rd}) begin
            failures++;
            $display("FAIL mem_stage t=%0t got=%b exp=%b", $time,
                     {mem_valid, mem_read, mem_write, mem_rd},
                     {q[1].v, q[1].mem_read, q[1].mem_write, q[1].rd});
        end
        checks++;
        if ({wb_valid, wb_reg_write, wb_reg_src, wb_rd} !==
            {q[0].v, q[0].reg_write, q[0].reg_src, q[0].rd}) begin
            failures++;
            $display("FAIL wb_stage t=%0t got=%b exp=%b", $time,
                     {wb_valid, wb_reg_write, wb_reg_src, wb_rd},
                     {q[0].v, q[0].reg_write, q[0].reg_src, q[0].rd});
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        ex_redirect = 1'b0;
        ext_stall   = 1'b0;
        illegal_clr = 1'b0;
        idle();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        q.push_back(BUB);
        q.push_back(BUB);
        q.push_back(BUB);
    endtask

    task automatic flush3();
        idle();
        for (int i = 0; i < 3; i++) sb_step(BUB, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (d1_all !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", d1_all);
        end
        checks++;
        if (d2_all !== '0) begin
            failures++;
            $display("FAIL reset_outputs_nohaz got=%h exp=0", d2_all);
        end
    endtask

    task automatic test_decode_sweep();
        logic [6:0] ops [10];
        ops = '{7'h33, 7'h13, 7'h03, 7'h0F, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, ops[i], 5'd1, 5'd2, 5'd5);
            #1;
            checks++;
            if (id_stall !== 1'b0) begin
                failures++;
                $display("FAIL sweep_no_stall op=%h got=%b exp=0", ops[i], id_stall);
            end
            sb_step(model(ops[i], 5'd5), 1'b0);
        end
        flush3();
        checks++;
        if (illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL sweep_legal got=%b exp=0", illegal_op);
        end
        checks++;
        if (d2_illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL fence_illegal_when_disabled got=%b exp=1", d2_illegal_op);
        end
    endtask

    task automatic test_illegal();
        idle();
        illegal_clr = 1'b1;
        sb_step(BUB, 1'b0);
        illegal_clr = 1'b0;
        checks++;
        if ({illegal_op, d2_illegal_op} !== 2'b00) begin
            failures++;
            $display("FAIL illegal_clear got=%b exp=00", {illegal_op, d2_illegal_op});
        end
        drive(1'b0, 7'h7F, 5'd0, 5'd0, 5'd5);
        sb_step(BUB, 1'b0);
        checks++;
        if (illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL illegal_invalid_id got=%b exp=0", illegal_op);
        end
        drive(1'b1, 7'h7F, 5'd0, 5'd0, 5'd5);
        illegal_clr = 1'b1;
        sb_step(BUB, 1'b0);
        checks++;
        if (illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL illegal_set_beats_clr got=%b exp=1", illegal_op);
        end
        idle();
        sb_step(BUB, 1'b0);
        illegal_clr = 1'b0;
        checks++;
        if (illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL illegal_clr_alone got=%b exp=0", illegal_op);
        end
        drive(1'b1, 7'h7F, 5'd0, 5'd0, 5'd5);
        sb_step(BUB, 1'b0);
        checks++;
        if (illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL illegal_set got=%b exp=1", illegal_op);
        end
        flush3();
        checks++;
        if ({wb_valid, illegal_op} !== 2'b01) begin
            failures++;
            $display("FAIL illegal_bubble_sticky got=%b exp=01", {wb_valid, illegal_op});
        end
        illegal_clr = 1'b1;
        sb_step(BUB, 1'b0);
        illegal_clr = 1'b0;
    endtask

    task automatic test_load_use();
        drive(1'b1, 7'h03, 5'd1, 5'd0, 5'd3);
        sb_step(model(7'h03, 5'd3), 1'b0);
        drive(1'b1, 7'h33, 5'd4, 5'd3, 5'd7);
        #1;
        checks++;
        if ({id_stall, if_flush, d2_id_stall} !== 3'b100) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=100", {id_stall, if_flush, d2_id_stall});
        end
        sb_step(BUB, 1'b0);
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL load_use_one_cycle got=%b exp=0", id_stall);
        end
        sb_step(model(7'h33, 5'd7), 1'b0);
        idle();
        sb_step(BUB, 1'b0);
        sb_step(BUB, 1'b0);
        checks++;
        if ({wb_valid, wb_rd} !== {1'b1, 5'd7}) begin
            failures++;
            $display("FAIL load_use_wb_cycle5 got=%b exp=%b", {wb_valid, wb_rd}, {1'b1, 5'd7});
        end
        sb_step(BUB, 1'b0);
    endtask

    task automatic test_redirect();
        drive(1'b1, 7'h33, 5'd1, 5'd2, 5'd8);
        sb_step(model(7'h33, 5'd8), 1'b0);
        drive(1'b1, 7'h23, 5'd1, 5'd2, 5'd0);
        ex_redirect = 1'b1;
        #1;
        checks++;
        if ({if_flush, id_stall} !== 2'b10) begin
            failures++;
            $display("FAIL redirect_flush got=%b exp=10", {if_flush, id_stall});
        end
        sb_step(BUB, 1'b0);
        ex_redirect = 1'b0;
        idle();
        sb_step(BUB, 1'b0);
        checks++;
        if (mem_write !== 1'b0) begin
            failures++;
            $display("FAIL redirect_no_store got=%b exp=0", mem_write);
        end
        sb_step(BUB, 1'b0);
        sb_step(BUB, 1'b0);
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 7'h03, 5'd1, 5'd2, 5'd3);
        sb_step(model(7'h03, 5'd3), 1'b0);
        drive(1'b1, 7'h33, 5'd3, 5'd0, 5'd9);
        ex_redirect = 1'b1;
        #1;
        checks++;
        if ({if_flush, id_stall} !== 2'b10) begin
            failures++;
            $display("FAIL redirect_over_load_use got=%b exp=10", {if_flush, id_stall});
        end
        sb_step(BUB, 1'b0);
        ex_redirect = 1'b0;
        flush3();
    endtask

    task automatic test_ext_stall();
        drive(1'b1, 7'h33, 5'd1, 5'd2, 5'd11);
        sb_step(model(7'h33, 5'd11), 1'b0);
        drive(1'b1, 7'h03, 5'd1, 5'd2, 5'd12);
        sb_step(model(7'h03, 5'd12), 1'b0);
        drive(1'b1, 7'h13, 5'd1, 5'd2, 5'd13);
        sb_step(model(7'h13, 5'd13), 1'b0);
        drive(1'b1, 7'h7F, 5'd12, 5'd0, 5'd14);
        ext_stall   = 1'b1;
        ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({id_stall, if_flush} !== 2'b10) begin
                failures++;
                $display("FAIL ext_stall_ctrl cyc=%0d got=%b exp=10", i, {id_stall, if_flush});
            end
            sb_step(BUB, 1'b1);
        end
        checks++;
        if (illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL ext_stall_flag_frozen got=%b exp=0", illegal_op);
        end
        ext_stall   = 1'b0;
        ex_redirect = 1'b0;
        drive(1'b1, 7'h33, 5'd1, 5'd2, 5'd15);
        sb_step(model(7'h33, 5'd15), 1'b0);
        flush3();
    endtask

    task automatic test_rd_zero();
        drive(1'b1, 7'h33, 5'd1, 5'd2, 5'd0);
        sb_step(model(7'h33, 5'd0), 1'b0);
        idle();
        sb_step(BUB, 1'b0);
        sb_step(BUB, 1'b0);
        checks++;
        if ({wb_valid, wb_reg_write} !== 2'b10) begin
            failures++;
            $display("FAIL rd0_no_write got=%b exp=10", {wb_valid, wb_reg_write});
        end
        drive(1'b1, 7'h03, 5'd1, 5'd2, 5'd0);
        sb_step(model(7'h03, 5'd0), 1'b0);
        drive(1'b1, 7'h33, 5'd0, 5'd0, 5'd6);
        #1;
        checks++;
        if (id_stall !== 1'b0) begin
            failures++;
            $display("FAIL rd0_load_no_stall got=%b exp=0", id_stall);
        end
        sb_step(model(7'h33, 5'd6), 1'b0);
        flush3();
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 7'h7F, 5'd0, 5'd0, 5'd1);
        sb_step(BUB, 1'b0);
        checks++;
        if (illegal_op !== 1'b1) begin
            failures++;
            $display("FAIL mid_illegal_set got=%b exp=1", illegal_op);
        end
        drive(1'b1, 7'h03, 5'd1, 5'd2, 5'd4);
        sb_step(model(7'h03, 5'd4), 1'b0);
        drive(1'b1, 7'h33, 5'd1, 5'd2, 5'd5);
        sb_step(model(7'h33, 5'd5), 1'b0);
        do_reset();
        checks++;
        if (d1_all !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h exp=0", d1_all);
        end
        drive(1'b1, 7'h13, 5'd1, 5'd2, 5'd6);
        sb_step(model(7'h13, 5'd6), 1'b0);
        flush3();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode_sweep();
        test_illegal();
        test_load_use();
        test_redirect();
        test_simultaneous();
        test_ext_stall();
        test_rd_zero();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes RV32I opcodes in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards (stall plus bubble), squashes on EX redirects, and flags illegal opcodes.
- Sits beside the datapath pipeline registers; the datapath consumes the per-stage outputs.

Parameters:
REG_ADDR_W, 5, register index width for rs1/rs2/rd
HAZ_DETECT, 1, 1 = load-use interlock enabled; 0 = id_stall tied 0 (compiler-inserted NOPs)
FENCE_NOP, 1, 1 = FENCE decodes as a legal bubble; 0 = FENCE flagged illegal

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  7  instruction[6:0]
id_rs1  in  REG_ADDR_W  source 1 index
id_rs2  in  REG_ADDR_W  source 2 index
id_rd  in  REG_ADDR_W  destination index
ex_redirect  in  1  EX resolved taken branch/JAL/JALR
ext_stall  in  1  global freeze (memory wait)
illegal_clr  in  1  clears illegal_op
id_stall  out  1  hold PC and IF/ID
if_flush  out  1  squash IF/ID
ex_valid  out  1  EX stage valid
ex_alu_op  out  2  0 = funct decode, 1 = ADD, 2 = SUB
ex_alu_src  out  1  0 = rs2, 1 = immediate
ex_branch  out  1  conditional branch in EX
ex_mem_read  out  1  load in EX (hazard source)
ex_rd  out  REG_ADDR_W  EX destination
mem_valid  out  1  MEM stage valid
mem_read  out  1  data memory read
mem_write  out  1  data memory write
mem_rd  out  REG_ADDR_W  MEM destination
wb_valid  out  1  WB stage valid
wb_reg_write  out  1  register file write enable
wb_reg_src  out  2  0 = ALU, 1 = memory, 2 = PC+imm, 3 = PC+4
wb_rd  out  REG_ADDR_W  WB destination
illegal_op  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (rst=1 at an edge): every registered output is 0, all stages are bubbles, and illegal_op is 0. Reset mid-operation discards all in-flight control.
- Decode table (combinational in ID):
  - R: defaults, RegWrite=1.
  - OP-IMM: ALUSrc=1.
  - LOAD: ALUOp=1, ALUSrc=1, MemRead=1, RegSrc=1.
  - JALR: ALUSrc=1, RegSrc=3.
  - STORE: ALUOp=1, ALUSrc=1, MemWrite=1, RegWrite=0.
  - LUI: ALUOp=1, ALUSrc=1.
  - AUIPC: RegSrc=2.
  - JAL: RegSrc=3.
  - BRANCH: ALUOp=2, Branch=1, RegWrite=0.
  - FENCE: all writes 0.
  - Any other opcode is illegal.
- RegWrite is forced to 0 when rd=0.
- Source usage:
  - rs1 is used by all opcodes except LUI, AUIPC, JAL and FENCE.
  - rs2 is used by R, STORE and BRANCH only.
- Latency: 1 cycle per stage. The ID decode of cycle N appears at ex_* in N+1, mem_* in N+2 and wb_* in N+3.
- Bubble: valid=0, with reg_write, mem_read, mem_write and branch all 0. Other fields are don't-care but driven to 0.
- Per-edge priority, highest first:
  1. rst
  2. ext_stall=1: every stage register holds; id_stall=1, if_flush=0; the illegal flag does not update.
  3. ex_redirect=1: if_flush=1. A bubble enters EX in place of the ID instruction. EX advances to MEM normally. No load-use stall is raised.
  4. Load-use (HAZ_DETECT=1): a stall is raised when ex_valid, ex_mem_read, ex_rd≠0 and ex_rd matches a used source of a valid ID instruction. Then id_stall=1 and a bubble enters EX; the ID instruction re-decodes next cycle.
  5. Otherwise ID advances.
- The load-use stall lasts exactly 1 cycle per hazard (after it, the load is in MEM and forwarding resolves).
- Illegal opcode with id_valid, not stalled, not flushed:
  - the instruction is converted to a bubble;
  - illegal_op is set at the edge.
- illegal_clr clears the flag. If set and clear coincide, set wins.
- id_valid=0 inserts a bubble and never raises a stall or an illegal flag.

Decomposition:
- Package rv32i_ctrl_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_I_LD, OP_I_FENCE, OP_I_JALR, OP_S, OP_B, OP_U_LUI, OP_U_AUIPC, OP_J);
  - ALUOp and RegSrc encodings;
  - the control-bundle field widths.
- One sub-module: ctrl_decode, a purely combinational opcode → bundle + legal + uses_rs1/uses_rs2. The pipeline registers and hazard logic stay in pipe_ctrl_unit.

Test Plan:
- Decode sweep: each legal opcode with rd=5 → EX/MEM/WB fields match the table 1/2/3 cycles later. opcode 0x7F → illegal_op=1 next cycle, wb_valid=0 three cycles later.
- Load-use: LOAD rd=3, then ADD rs2=3 → id_stall=1 for exactly one cycle, a bubble appears at ex_valid, and the ADD reaches WB at cycle 5. Same sequence with HAZ_DETECT=0 → no stall.
- Redirect: ex_redirect=1 with a STORE in ID → if_flush=1, and mem_write=0 on the following cycle.
- Simultaneous: ex_redirect=1 together with a load-use match → if_flush=1 and id_stall=0. ext_stall=1 for 3 cycles mid-stream → all outputs frozen, then resume intact.
- rd=0: ADD rd=0 → wb_reg_write=0. LOAD rd=0 followed by a dependent rs1=0 → no stall.
- Reset mid-stream, plus illegal_clr together with a new illegal → all outputs 0 after rst; illegal_op remains 1 when set and clear coincide.
